// File: rtl/axi_pkg.sv
// Shared AXI types and constants for the write master.
package axi_pkg;
`include "AXI_define.svh"

  localparam int AXI_ADDR_W = `AXI_ADDR_BITS;
  localparam int AXI_LEN_W  = `AXI_LEN_BITS;
  localparam int AXI_ID_W   = `AXI_ID_BITS;
  localparam int AXI_DATA_W = `AXI_DATA_BITS;
  localparam int AXI_STRB_W = `AXI_STRB_BITS;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INC   = `AXI_BURST_INC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP_WAIT,
    ST_REPORT
  } wm_state_e;
endpackage

// File: rtl/AXI_define.svh
// AXI widths and encodings shared by the write master and its bench.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ADDR_BITS  32
`define AXI_LEN_BITS   8
`define AXI_ID_BITS    4
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2
`define AXI_BURST_INC  2'b01
`endif

// File: rtl/axi_wm_timer.sv
// Response-wait timer: cleared outside the wait state, counts while enabled.
module axi_wm_timer #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A zero limit means wait forever.
  assign expired = (LIMIT != 0) && enable && (cnt_reg == LAST);
endmodule

// File: rtl/axi_write_master.sv
// AXI write initiator: one command -> AW, W beats (pass-through), B -> response record.
`include "AXI_define.svh"
module axi_write_master
  import axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [`AXI_ADDR_BITS-1:0]  cmd_addr,
  input  logic [`AXI_LEN_BITS-1:0]   cmd_len,
  input  logic [`AXI_ID_BITS-1:0]    cmd_id,
  input  logic                       wd_valid,
  output logic                       wd_ready,
  input  logic [`AXI_DATA_BITS-1:0]  wd_data,
  input  logic [`AXI_STRB_BITS-1:0]  wd_strb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_resp,
  output logic [`AXI_ID_BITS-1:0]    rsp_id,
  output logic                       rsp_timeout,
  output logic [`AXI_ID_BITS-1:0]    AWID_M,
  output logic [`AXI_ADDR_BITS-1:0]  AWADDR_M,
  output logic [`AXI_LEN_BITS-1:0]   AWLEN_M,
  output logic [`AXI_SIZE_BITS-1:0]  AWSIZE_M,
  output logic [`AXI_BURST_BITS-1:0] AWBURST_M,
  output logic                       AWVALID_M,
  input  logic                       AWREADY_M,
  output logic [`AXI_DATA_BITS-1:0]  WDATA_M,
  output logic [`AXI_STRB_BITS-1:0]  WSTRB_M,
  output logic                       WLAST_M,
  output logic                       WVALID_M,
  input  logic                       WREADY_M,
  input  logic [`AXI_ID_BITS-1:0]    BID_M,
  input  logic [`AXI_RESP_BITS-1:0]  BRESP_M,
  input  logic                       BVALID_M,
  output logic                       BREADY_M
);
  wm_state_e state_reg, state_next;

  logic [`AXI_ADDR_BITS-1:0] addr_reg;
  logic [`AXI_LEN_BITS-1:0]  len_reg;
  logic [`AXI_ID_BITS-1:0]   id_reg;
  logic [`AXI_LEN_BITS-1:0]  beat_cnt_reg;
  logic [1:0]                rsp_resp_reg;
  logic [`AXI_ID_BITS-1:0]   rsp_id_reg;
  logic                      rsp_timeout_reg;

  logic last_beat;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  axi_wm_timer #(
    .LIMIT(TIMEOUT_CYCLES),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(timer_expired)
  );

  assign last_beat = (beat_cnt_reg == len_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    AWVALID_M  = 1'b0;
    WVALID_M   = 1'b0;
    wd_ready   = 1'b0;
    WLAST_M    = 1'b0;
    BREADY_M   = 1'b0;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        // Stray or late B beats are drained and dropped here.
        BREADY_M  = 1'b1;
        if (cmd_valid) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        AWVALID_M = 1'b1;
        if (AWREADY_M) state_next = ST_DATA;
      end
      ST_DATA: begin
        WVALID_M = wd_valid;
        wd_ready = WREADY_M;
        WLAST_M  = last_beat;
        if (wd_valid && WREADY_M && last_beat) state_next = ST_RESP_WAIT;
      end
      ST_RESP_WAIT: begin
        BREADY_M  = 1'b1;
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        if (BVALID_M || timer_expired) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg        <= '0;
      len_reg         <= '0;
      id_reg          <= '0;
      beat_cnt_reg    <= '0;
      rsp_resp_reg    <= '0;
      rsp_id_reg      <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && cmd_valid) begin
        addr_reg     <= cmd_addr;
        len_reg      <= cmd_len;
        id_reg       <= cmd_id;
        beat_cnt_reg <= '0;
      end
      if (state_reg == ST_DATA && wd_valid && WREADY_M) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      // A B beat arriving on the expiry cycle still counts as a real response.
      if (state_reg == ST_RESP_WAIT) begin
        if (BVALID_M) begin
          rsp_resp_reg    <= BRESP_M;
          rsp_id_reg      <= BID_M;
          rsp_timeout_reg <= 1'b0;
        end else if (timer_expired) begin
          rsp_resp_reg    <= AXI_RESP_DECERR;
          rsp_id_reg      <= id_reg;
          rsp_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign AWID_M      = id_reg;
  assign AWADDR_M    = addr_reg;
  assign AWLEN_M     = len_reg;
  assign AWSIZE_M    = AXI_SIZE_4B;
  assign AWBURST_M   = AXI_BURST_INC;
  assign WDATA_M     = wd_data;
  assign WSTRB_M     = wd_strb;
  assign rsp_valid   = (state_reg == ST_REPORT);
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_timeout = rsp_timeout_reg;
endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: table of write transactions against a small slave model with scoreboards.
module tb_axi_write_master;
  import axi_pkg::*;

  localparam int TO = 16;

  logic                  clk, rst;
  logic                  cmd_valid, cmd_ready;
  logic [AXI_ADDR_W-1:0] cmd_addr;
  logic [AXI_LEN_W-1:0]  cmd_len;
  logic [AXI_ID_W-1:0]   cmd_id;
  logic                  wd_valid, wd_ready;
  logic [AXI_DATA_W-1:0] wd_data;
  logic [AXI_STRB_W-1:0] wd_strb;
  logic                  rsp_valid, rsp_ready, rsp_timeout;
  logic [1:0]            rsp_resp;
  logic [AXI_ID_W-1:0]   rsp_id;
  logic [AXI_ID_W-1:0]   AWID_M, BID_M;
  logic [AXI_ADDR_W-1:0] AWADDR_M;
  logic [AXI_LEN_W-1:0]  AWLEN_M;
  logic [2:0]            AWSIZE_M;
  logic [1:0]            AWBURST_M, BRESP_M;
  logic                  AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
  logic [AXI_DATA_W-1:0] WDATA_M;
  logic [AXI_STRB_W-1:0] WSTRB_M;

  axi_write_master #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
    .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr; logic [7:0] len; logic [3:0] id; logic [31:0] data0; logic [3:0] strb;
    int aw_delay; bit w_toggle; bit b_en; int b_delay; logic [1:0] bresp; logic [3:0] bid;
    int rsp_delay; int abort_beats; bit late_b;
    logic [1:0] exp_resp; logic [3:0] exp_id; bit exp_to; int exp_lat; int exp_w2r;
  } vec_t;

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } aw_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; logic to; } rsp_exp_t;

  aw_exp_t  aw_q[$];
  w_exp_t   w_q[$];
  rsp_exp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rsp_ready = 1'b0;
    AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0; BRESP_M = '0; BID_M = '0;
  endtask

  task automatic run_txn(input int n, input vec_t v);
    int beats_sent = 0, aw_seen = 0, rsp_seen = 0;
    int c0 = -1, cw = -1, crsp = -1;
    bit cmd_sent = 0, wlast_seen = 0, b_done = 0, done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      cmd_valid = !cmd_sent;
      cmd_addr  = v.addr; cmd_len = v.len; cmd_id = v.id;
      wd_valid  = (beats_sent <= int'(v.len));
      wd_data   = v.data0 + 32'(beats_sent);
      wd_strb   = v.strb;
      AWREADY_M = (aw_seen >= v.aw_delay);
      WREADY_M  = v.w_toggle ? c[0] : 1'b1;
      BVALID_M  = v.b_en && wlast_seen && !b_done && (c >= cw + 1 + v.b_delay);
      BRESP_M   = v.bresp; BID_M = v.bid;
      rsp_ready = (rsp_seen >= v.rsp_delay);
      #1;
      if (v.abort_beats != 0 && beats_sent == v.abort_beats) begin
        rst = 1'b0;
        #1;
        chk("abort_awvalid", 64'(AWVALID_M), 64'd0);
        chk("abort_wvalid", 64'(WVALID_M), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_bready", 64'(BREADY_M), 64'd1);
        idle_inputs();
        aw_q.delete(); w_q.delete(); rsp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
          chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        $display("txn %0d: aborted by reset after %0d beats", n, beats_sent);
        return;
      end
      if (cmd_valid && cmd_ready) begin
        cmd_sent = 1; c0 = c;
        aw_q.push_back('{addr: v.addr, len: v.len, id: v.id});
        for (int i = 0; i <= int'(v.len); i++)
          w_q.push_back('{data: v.data0 + 32'(i), strb: v.strb, last: (i == int'(v.len))});
        rsp_q.push_back('{resp: v.exp_resp, id: v.exp_id, to: v.exp_to});
      end
      if (AWVALID_M) begin
        aw_seen++;
        if (aw_q.size() == 0) chk("aw_unexpected", 64'(AWVALID_M), 64'd0);
        else begin
          chk("aw_addr", 64'(AWADDR_M), 64'(aw_q[0].addr));
          chk("aw_len", 64'(AWLEN_M), 64'(aw_q[0].len));
          chk("aw_id", 64'(AWID_M), 64'(aw_q[0].id));
          chk("aw_size", 64'(AWSIZE_M), 64'(AXI_SIZE_4B));
          chk("aw_burst", 64'(AWBURST_M), 64'(AXI_BURST_INC));
          if (AWREADY_M) void'(aw_q.pop_front());
        end
      end
      if (WVALID_M) begin
        chk("w_before_aw", 64'(aw_q.size()), 64'd0);
        chk("wd_ready", 64'(wd_ready), 64'(WREADY_M));
        if (w_q.size() == 0) chk("w_unexpected", 64'(WVALID_M), 64'd0);
        else begin
          chk("w_data", 64'(WDATA_M), 64'(w_q[0].data));
          chk("w_strb", 64'(WSTRB_M), 64'(w_q[0].strb));
          chk("w_last", 64'(WLAST_M), 64'(w_q[0].last));
          if (WREADY_M) begin
            if (w_q[0].last) begin wlast_seen = 1; cw = c; end
            void'(w_q.pop_front());
            beats_sent++;
          end
        end
      end else if (!cmd_sent || aw_q.size() != 0) begin
        chk("wlast_idle", 64'(WLAST_M), 64'd0);
      end
      if (BVALID_M) begin
        chk("bready_resp", 64'(BREADY_M), 64'd1);
        b_done = 1;
      end
      if (rsp_valid) begin
        chk("cmd_ready_in_report", 64'(cmd_ready), 64'd0);
        if (crsp < 0) crsp = c;
        if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          chk("rsp_resp", 64'(rsp_resp), 64'(rsp_q[0].resp));
          chk("rsp_id", 64'(rsp_id), 64'(rsp_q[0].id));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(rsp_q[0].to));
          rsp_seen++;
          if (rsp_ready) begin void'(rsp_q.pop_front()); done = 1; end
        end
      end
    end
    if (!done) chk("txn_cycle_budget", 64'(done), 64'd1);
    chk("w_beats_all_seen", 64'(w_q.size()), 64'd0);
    if (v.exp_lat != 0) chk("latency_cmd_to_rsp", 64'(crsp - c0), 64'(v.exp_lat));
    chk("latency_wlast_to_rsp", 64'(crsp - cw), 64'(v.exp_w2r));
    if (v.rsp_delay != 0) chk("rsp_hold_cycles", 64'(rsp_seen), 64'(v.rsp_delay + 1));
    cmd_valid = 1'b0; wd_valid = 1'b0; BVALID_M = 1'b0;
    @(negedge clk); #1;
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
    chk("rsp_valid_after_rsp", 64'(rsp_valid), 64'd0);
    if (v.late_b) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        BVALID_M = (k == 4); BRESP_M = AXI_RESP_OKAY; BID_M = v.id;
        #1;
        if (k == 4) chk("late_b_sunk", 64'(BREADY_M), 64'd1);
        chk("late_b_no_rsp", 64'(rsp_valid), 64'd0);
      end
      BVALID_M = 1'b0;
    end
    $display("txn %0d: addr=%08h len=%0d id=%0h rsp_resp=%0d rsp_id=%0h timeout=%0d", n, v.addr, v.len, v.id, rsp_resp, rsp_id, rsp_timeout);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{addr: 32'h1000_0100, len: 8'd0, id: 4'h3, data0: 32'h1, strb: 4'hF, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: 0, bresp: 2'd0, bid: 4'h3, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd0, exp_id: 4'h3, exp_to: 0, exp_lat: 4, exp_w2r: 2};
    vecs[1] = '{addr: 32'h2000_0000, len: 8'd3, id: 4'h5, data0: 32'hA0, strb: 4'hF, aw_delay: 0, w_toggle: 1, b_en: 1, b_delay: 0, bresp: 2'd0, bid: 4'h5, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd0, exp_id: 4'h5, exp_to: 0, exp_lat: 0, exp_w2r: 2};
    vecs[2] = '{addr: 32'h3000_0040, len: 8'd1, id: 4'h7, data0: 32'h55, strb: 4'h3, aw_delay: 10, w_toggle: 0, b_en: 1, b_delay: 0, bresp: 2'd2, bid: 4'h7, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd2, exp_id: 4'h7, exp_to: 0, exp_lat: 0, exp_w2r: 2};
    vecs[3] = '{addr: 32'h4000_0000, len: 8'd0, id: 4'h9, data0: 32'h77, strb: 4'hF, aw_delay: 0, w_toggle: 0, b_en: 0, b_delay: 0, bresp: 2'd0, bid: 4'h0, rsp_delay: 0, abort_beats: 0, late_b: 1, exp_resp: 2'd3, exp_id: 4'h9, exp_to: 1, exp_lat: 0, exp_w2r: TO + 1};
    vecs[4] = '{addr: 32'h5000_0010, len: 8'd2, id: 4'h6, data0: 32'hC0, strb: 4'h8, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: 3, bresp: 2'd3, bid: 4'hA, rsp_delay: 8, abort_beats: 0, late_b: 0, exp_resp: 2'd3, exp_id: 4'hA, exp_to: 0, exp_lat: 0, exp_w2r: 5};
    vecs[5] = '{addr: 32'h6000_0000, len: 8'd0, id: 4'h2, data0: 32'h99, strb: 4'hF, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: TO - 1, bresp: 2'd1, bid: 4'h2, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd1, exp_id: 4'h2, exp_to: 0, exp_lat: 0, exp_w2r: TO + 1};
    vecs[6] = '{addr: 32'h6000_0100, len: 8'd0, id: 4'hB, data0: 32'h9A, strb: 4'h1, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: TO - 2, bresp: 2'd0, bid: 4'hB, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd0, exp_id: 4'hB, exp_to: 0, exp_lat: 0, exp_w2r: TO};
    vecs[7] = '{addr: 32'h7000_0000, len: 8'd3, id: 4'h4, data0: 32'hD0, strb: 4'hF, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: 0, bresp: 2'd0, bid: 4'h4, rsp_delay: 0, abort_beats: 2, late_b: 0, exp_resp: 2'd0, exp_id: 4'h4, exp_to: 0, exp_lat: 0, exp_w2r: 2};
    vecs[8] = '{addr: 32'h1000_0100, len: 8'd0, id: 4'h1, data0: 32'h2, strb: 4'hF, aw_delay: 0, w_toggle: 0, b_en: 1, b_delay: 0, bresp: 2'd0, bid: 4'h1, rsp_delay: 0, abort_beats: 0, late_b: 0, exp_resp: 2'd0, exp_id: 4'h1, exp_to: 0, exp_lat: 4, exp_w2r: 2};

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_awvalid", 64'(AWVALID_M), 64'd0);
    chk("reset_wvalid", 64'(WVALID_M), 64'd0);
    chk("reset_wlast", 64'(WLAST_M), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("reset_bready", 64'(BREADY_M), 64'd1);
    chk("reset_awaddr", 64'(AWADDR_M), 64'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- AXI write initiator (master side of the AW/W/B channels) for on-chip agents: DMA engine, CPU store path, test sequencers.
- Accepts one write command (address, burst length, ID) plus a stream of data beats.
- Drives AW, then W beats, then collects B, and returns a response record to the requester.
- Pairs with the write-only slave wrappers on the bus, e.g. the WDT register port.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for BVALID after the last W beat; 0 disables the timeout.
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  `AXI_ADDR_BITS  burst start address
- cmd_len  in  `AXI_LEN_BITS  beats-1
- cmd_id  in  `AXI_ID_BITS  transaction ID
- wd_valid  in  1  data beat valid
- wd_ready  out  1  data beat accepted
- wd_data  in  `AXI_DATA_BITS  beat data
- wd_strb  in  `AXI_STRB_BITS  beat strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_resp  out  2  BRESP, or DECERR on timeout
- rsp_id  out  `AXI_ID_BITS  BID received (cmd_id on timeout)
- rsp_timeout  out  1  response produced by timeout
- AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M  out  per AXI_define  write address channel
- AWREADY_M  in  1  write address ready
- WDATA_M, WSTRB_M, WLAST_M, WVALID_M  out  per AXI_define  write data channel
- WREADY_M  in  1  write data ready
- BID_M, BRESP_M, BVALID_M  in  per AXI_define  write response channel
- BREADY_M  out  1  write response ready

Behaviour:
- Reset (rst low, async): state IDLE; AWVALID_M, WVALID_M, rsp_valid, rsp_timeout = 0; beat and timeout counters = 0; captured command regs = 0; BREADY_M = 1 (IDLE sink); cmd_ready = 1 after reset release. Reset mid-burst aborts silently; no response is produced.
- FSM states: IDLE, ADDR, DATA, RESP_WAIT, REPORT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register addr/len/id, clear beat counter, go to ADDR.
  - BREADY_M = 1 to drain stray B beats; stray B is discarded.
- ADDR:
  - AWVALID_M = 1.
  - AWADDR_M, AWLEN_M, AWID_M come from registers and stay stable until the handshake.
  - AWSIZE_M = 3'b010; AWBURST_M = `AXI_BURST_INC.
  - On AWREADY_M: go to DATA the next cycle.
- DATA:
  - WVALID_M = wd_valid; wd_ready = WREADY_M. Pass-through, zero latency, no buffering.
  - WDATA_M / WSTRB_M = wd_data / wd_strb.
  - WLAST_M = (beat_cnt == len_reg). beat_cnt increments on each W handshake.
  - The handshake with WLAST_M high goes to RESP_WAIT. len = 0 is a single beat with WLAST on the first beat.
  - Outside DATA: WVALID_M = 0, wd_ready = 0, WLAST_M = 0.
- RESP_WAIT:
  - BREADY_M = 1; timeout counter increments each cycle.
  - On BVALID_M: capture BRESP_M/BID_M, rsp_timeout = 0, go to REPORT.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without BVALID: rsp_resp = 2'b11, rsp_id = id_reg, rsp_timeout = 1, go to REPORT.
  - BVALID in the same cycle as expiry wins; it is a normal response.
- REPORT:
  - rsp_valid = 1, outputs stable.
  - On rsp_ready: go to IDLE. cmd_ready returns the next cycle, so back-to-back commands are spaced by one cycle minimum.
  - BREADY_M = 0 in ADDR, DATA and REPORT.
- A late B after a timeout is sunk in IDLE. A BID mismatch is not checked; BID is reported as-is.
- Latency, all-ready slave, len = 0: cmd accepted at T0; AW handshake at T1; W handshake at T2; B sampled at T3; rsp_valid at T4.

Decomposition:
- Shared package (axi_pkg): FSM state enum, AXI_RESP_OKAY/SLVERR/DECERR constants, AXI_SIZE_4B, AXI_BURST_INC.
- Header AXI_define.svh supplies the widths.
- One natural sub-module: axi_wm_timer (load/clear, enable, expire flag) holds the timeout counter. The rest is flat.

Test Plan:
- Single write: cmd addr=0x1000_0100, len=0, id=3, data=0x1, strb=0xF; slave always ready with BRESP=OKAY -> AW one cycle, W one beat with WLAST, rsp_valid at T4 with resp=0, id=3, timeout=0.
- 4-beat burst, len=3, data 0xA0..0xA3; slave WREADY toggles every other cycle -> exactly 4 W handshakes in order, WLAST only on 0xA3, AW/W payloads stable while stalled.
- AWREADY held low 10 cycles -> AWVALID_M stays 1 with stable payload; no W activity until the AW handshake.
- No BVALID, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after entering RESP_WAIT, resp=2'b11, rsp_timeout=1. A BVALID driven 5 cycles later is accepted in IDLE and no second rsp is produced.
- rsp_ready held low 8 cycles, then high -> rsp stable; cmd_ready=0 throughout; cmd_ready=1 one cycle after the accept.
- Assert rst low during DATA beat 2 of 4 -> all VALIDs 0 asynchronously, state IDLE, no rsp. A following single write completes normally.
